// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta level decoder: FSM state type,
// default window/level widths and the level shift/saturate helper.
package sd_pkg;

  localparam int WIN_LOG2_DEF = 6;
  localparam int LVL_W_DEF    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Scale a ones-count down to the level width and clamp it. A full window
  // counts 2^win_log2 ones, one more than the level range can hold, so the
  // clamp keeps an all-ones window at full scale instead of wrapping to 0.
  function automatic int unsigned sat_level(input int unsigned ones,
                                            input int unsigned shift,
                                            input int unsigned lvl_w);
    int unsigned lvl;
    int unsigned lim;
    lvl = ones >> shift;
    lim = (32'd1 << lvl_w) - 32'd1;
    return (lvl > lim) ? lim : lvl;
  endfunction

endpackage

// File: rtl/sd_level_decoder_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous input, cleared to 0 on
// reset. Generic enough for any async control input, not just the bitstream.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sd_level_decoder.sv
// Sigma-delta / PWM bitstream decoder: counts ones over a window of
// 2^WIN_LOG2 clocks and emits one level per window over valid/ready.
// Optional build macro: SD_DECODE_SMOOTH_EN averages each level with the
// previous window's level (rounded) before it is presented on o_level.
//
// state | meaning
// IDLE  | disabled, counters clear, waiting for en
// ACQ   | accumulating samples of the current window
// EMIT  | window complete; publish level and count sample 0 of next window
module sd_level_decoder
  import sd_pkg::*;
#(
  parameter int WIN_LOG2    = WIN_LOG2_DEF,
  parameter int LVL_W       = LVL_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             en,
  input  logic             i_bit,
  output logic [LVL_W-1:0] o_level,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overrun
);

  localparam int SHIFT = WIN_LOG2 - LVL_W;

  state_t              state;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   ones;
  logic                s_bit;
  logic [LVL_W-1:0]    lvl;
  logic [LVL_W-1:0]    out_lvl;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_bit),
    .q     (s_bit)
  );

  assign lvl = LVL_W'(sat_level(32'(ones), SHIFT, LVL_W));

`ifdef SD_DECODE_SMOOTH_EN
  logic [LVL_W-1:0] prev_lvl;
  logic [LVL_W:0]   smooth_sum;

  // Remember the raw level of every completed window, published or not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_lvl <= '0;
    end else if (!en) begin
      prev_lvl <= '0;
    end else if (state == EMIT) begin
      prev_lvl <= lvl;
    end
  end

  assign smooth_sum = {1'b0, prev_lvl} + {1'b0, lvl} + (LVL_W+1)'(1);
  assign out_lvl    = smooth_sum[LVL_W:1];
`else
  assign out_lvl = lvl;
`endif

  // Window FSM with the output handshake registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      win_cnt   <= '0;
      ones      <= '0;
      o_level   <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      // Consumption; an EMIT that publishes below overrides this.
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (!en) begin
        state     <= IDLE;
        win_cnt   <= '0;
        ones      <= '0;
        o_overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ACQ;
            win_cnt <= '0;
            ones    <= '0;
          end
          ACQ: begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
            ones    <= ones + (WIN_LOG2+1)'(s_bit);
            if (&win_cnt) begin
              state <= EMIT;
            end
          end
          EMIT: begin
            if (!o_valid || i_ready) begin
              o_level <= out_lvl;
              o_valid <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
            // This cycle's sample is sample 0 of the next window.
            win_cnt <= WIN_LOG2'(1);
            ones    <= (WIN_LOG2+1)'(s_bit);
            state   <= ACQ;
          end
          default: begin
            state   <= IDLE;
            win_cnt <= '0;
            ones    <= '0;
          end
        endcase
      end
    end
  end

endmodule
